// File: rtl/vga_fb_fetch_pkg.sv
// Shared types and constants for the VGA framebuffer fetch scheduler.
package vga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_CHECK = 3'd2,
        ST_REQ   = 3'd3,
        ST_DATA  = 3'd4
    } vga_fetch_state_e;

    localparam int VGA_FETCH_WORD_BYTES = 4;

endpackage

// File: rtl/vga_fb_fetch_credit.sv
// Burst sizing and FIFO room check for the framebuffer fetch scheduler.
module vga_fetch_credit
    import vga_pkg::*;
#(
    parameter int RW         = 30,
    parameter int FIFO_DEPTH = 64
) (
    input  logic [8:0]                    i_blen,
    input  logic [RW-1:0]                 i_remain,
    input  logic [$clog2(FIFO_DEPTH):0]   i_fifo_level,
    output logic [8:0]                    o_beats,
    output logic                          o_room
);

    // Wide enough for the level plus a full 256-beat burst.
    localparam int CW = ($clog2(FIFO_DEPTH) + 2 > 10) ? ($clog2(FIFO_DEPTH) + 2) : 10;

    logic [8:0] w_beats;

    assign w_beats = (i_remain < RW'(i_blen)) ? i_remain[8:0] : i_blen;
    assign o_beats = w_beats;
    assign o_room  = ((CW'(i_fifo_level) + CW'(w_beats)) <= CW'(FIFO_DEPTH));

endmodule

// File: rtl/vga_fb_fetch.sv
// Per-frame framebuffer burst-read scheduler with FIFO-level throttling.
// Optional underrun monitor enabled by defining VGA_FETCH_UNDERRUN_EN.
module vga_fb_fetch
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [7:0]                    brulen_i,
    input  logic [ADDR_WIDTH-1:0]         fbstart_i,
    input  logic [ADDR_WIDTH-1:0]         fbsize_i,
    input  logic                          frame_start_i,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_level_i,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    output logic [ADDR_WIDTH-1:0]         req_addr_o,
    output logic [7:0]                    req_len_o,
    input  logic                          rsp_valid_i,
    output logic                          busy_o,
`ifdef VGA_FETCH_UNDERRUN_EN
    input  logic                          fifo_empty_i,
    input  logic                          de_i,
    output logic                          underrun_o,
    output logic [15:0]                   underrun_cnt_o,
`endif
    output logic                          frame_done_o
);

    localparam int RW = ADDR_WIDTH - 2;

    vga_fetch_state_e      r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [RW-1:0]         r_remain;
    logic [8:0]            r_blen;
    logic [8:0]            r_beat_cnt;
    logic                  r_restart_pend;
    logic                  r_stop_pend;
    logic                  r_req_valid;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [7:0]            r_req_len;
    logic                  r_busy;
    logic                  r_frame_done;

    logic [ADDR_WIDTH-1:0] w_start_addr;
    logic [RW-1:0]         w_remain_init;
    logic [8:0]            w_blen_init;
    logic [8:0]            w_beats;
    logic                  w_room;
    logic                  w_unused;

    assign w_start_addr  = {fbstart_i[ADDR_WIDTH-1:2], 2'b00};
    assign w_remain_init = fbsize_i[ADDR_WIDTH-1:2];
    assign w_blen_init   = {1'b0, brulen_i} + 9'd1;
    assign w_unused      = ^{fbstart_i[1:0], fbsize_i[1:0]};

    vga_fetch_credit #(
        .RW         (RW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_credit (
        .i_blen       (r_blen),
        .i_remain     (r_remain),
        .i_fifo_level (fifo_level_i),
        .o_beats      (w_beats),
        .o_room       (w_room)
    );

    // Fetch FSM: frame latch, throttled request issue, beat counting, restart/stop handling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_cur_addr     <= '0;
            r_remain       <= '0;
            r_blen         <= 9'd0;
            r_beat_cnt     <= 9'd0;
            r_restart_pend <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_req_valid    <= 1'b0;
            r_req_addr     <= '0;
            r_req_len      <= 8'd0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en_i) begin
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!en_i) begin
                        r_state <= ST_IDLE;
                    end else if (frame_start_i) begin
                        r_cur_addr <= w_start_addr;
                        r_remain   <= w_remain_init;
                        r_blen     <= w_blen_init;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!en_i) begin
                        r_restart_pend <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else if (frame_start_i) begin
                        r_cur_addr     <= w_start_addr;
                        r_remain       <= w_remain_init;
                        r_blen         <= w_blen_init;
                        r_restart_pend <= 1'b0;
                    end else if (r_remain == '0) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_ARM;
                    end else if (w_room) begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= r_cur_addr;
                        r_req_len   <= w_beats[7:0] - 8'd1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (frame_start_i) begin
                        r_restart_pend <= 1'b1;
                    end
                    if (!en_i) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (req_ready_i) begin
                        r_req_valid <= 1'b0;
                        r_beat_cnt  <= 9'd0;
                        r_state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (frame_start_i) begin
                        r_restart_pend <= 1'b1;
                    end
                    if (!en_i) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (rsp_valid_i) begin
                        if ((r_beat_cnt + 9'd1) == w_beats) begin
                            if (r_stop_pend || !en_i) begin
                                r_stop_pend    <= 1'b0;
                                r_restart_pend <= 1'b0;
                                r_busy         <= 1'b0;
                                r_state        <= ST_IDLE;
                            end else if (r_restart_pend || frame_start_i) begin
                                r_cur_addr     <= w_start_addr;
                                r_remain       <= w_remain_init;
                                r_blen         <= w_blen_init;
                                r_restart_pend <= 1'b0;
                                r_state        <= ST_CHECK;
                            end else begin
                                r_cur_addr <= r_cur_addr + ADDR_WIDTH'(w_beats) * ADDR_WIDTH'(VGA_FETCH_WORD_BYTES);
                                r_remain   <= r_remain - RW'(w_beats);
                                r_state    <= ST_CHECK;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 9'd1;
                        end
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_valid_o  = r_req_valid;
    assign req_addr_o   = r_req_addr;
    assign req_len_o    = r_req_len;
    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;

`ifdef VGA_FETCH_UNDERRUN_EN
    logic        r_underrun;
    logic [15:0] r_underrun_cnt;

    // Sticky underrun flag and saturating counter, cleared on each armed frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'd0;
        end else if ((r_state == ST_ARM) && frame_start_i) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'd0;
        end else if (de_i && fifo_empty_i) begin
            r_underrun <= 1'b1;
            if (r_underrun_cnt != 16'hFFFF) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end
    end

    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Self-checking bench for vga_fb_fetch: bursts are predicted from the frame
// window arithmetic and compared as the DUT issues them.
module tb_vga_fb_fetch;

    localparam int AW = 32;
    localparam int FD = 64;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst_i, en_i, frame_start_i, req_ready_i, rsp_valid_i;
    logic [7:0]    brulen_i;
    logic [AW-1:0] fbstart_i, fbsize_i;
    logic [LW-1:0] fifo_level_i;
    logic          req_valid_o, busy_o, frame_done_o;
    logic [AW-1:0] req_addr_o;
    logic [7:0]    req_len_o;
`ifdef VGA_FETCH_UNDERRUN_EN
    logic          fifo_empty_i, de_i, underrun_o;
    logic [15:0]   underrun_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_addr[$];
    logic [7:0]  q_len[$];

    always #5 clk = ~clk;

    vga_fb_fetch #(.ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .brulen_i      (brulen_i),
        .fbstart_i     (fbstart_i),
        .fbsize_i      (fbsize_i),
        .frame_start_i (frame_start_i),
        .fifo_level_i  (fifo_level_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_addr_o    (req_addr_o),
        .req_len_o     (req_len_o),
        .rsp_valid_i   (rsp_valid_i),
        .busy_o        (busy_o),
`ifdef VGA_FETCH_UNDERRUN_EN
        .fifo_empty_i  (fifo_empty_i),
        .de_i          (de_i),
        .underrun_o    (underrun_o),
        .underrun_cnt_o(underrun_cnt_o),
`endif
        .frame_done_o  (frame_done_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: split the word-aligned window into bursts of at most bl+1 words.
    task automatic build(input logic [31:0] start, input logic [31:0] size, input logic [7:0] bl);
        logic [31:0] a;
        int unsigned rem, b, n;
        q_addr.delete();
        q_len.delete();
        a   = start & 32'hFFFF_FFFC;
        rem = size >> 2;
        b   = int'(bl) + 1;
        while (rem > 0) begin
            n = (rem < b) ? rem : b;
            q_addr.push_back(a);
            q_len.push_back(8'(n - 1));
            a   = a + 32'(n * 4);
            rem = rem - n;
        end
    endtask

    task automatic run_frame(input string tag, input logic [31:0] start, input logic [31:0] size,
                             input logic [7:0] bl, input bit rnd, input int restart_at, input int hold);
        int outstanding = 0;
        int delivered   = 0;
        int first_req   = -1;
        int done_cyc    = -1;
        int hold_viol   = 0;
        int overlap     = 0;
        int extra       = 0;
        int exp_nreq;
        int prev_level;
        bit restarted   = 1'b0;
        bit prev_valid  = 1'b0;
        fbstart_i = start;
        fbsize_i  = size;
        brulen_i  = bl;
        build(start, size, bl);
        exp_nreq = q_addr.size();
        fifo_level_i = (hold > 0) ? LW'($urandom_range(57, 64)) : LW'(0);
        @(negedge clk);
        frame_start_i = 1'b1;
        @(negedge clk);
        frame_start_i = 1'b0;
        prev_level = int'(fifo_level_i);
        for (int cyc = 0; cyc < 4000 && done_cyc < 0; cyc++) begin
            if (cyc == 0) chk({tag, " busy_start"}, 64'(busy_o), 64'd1);
            if (frame_done_o) done_cyc = cyc;
            if (req_valid_o && outstanding > 0) overlap++;
            if (req_valid_o && !prev_valid) begin
                if (first_req < 0) first_req = cyc;
                if (cyc < hold) hold_viol++;
                if (q_len.size() > 0)
                    chk({tag, " room"}, 64'((prev_level + int'(q_len[0]) + 1) <= FD), 64'd1);
            end
            prev_valid = req_valid_o;
            frame_start_i = 1'b0;
            if (restart_at > 0 && !restarted && delivered == restart_at) begin
                frame_start_i = 1'b1;
                restarted     = 1'b1;
                build(start, size, bl);
            end
            if (outstanding > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
                rsp_valid_i = 1'b1;
                outstanding--;
                delivered++;
            end else begin
                rsp_valid_i = 1'b0;
            end
            req_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (req_valid_o && req_ready_i) begin
                if (q_addr.size() == 0) begin
                    extra++;
                end else begin
                    chk({tag, " addr"}, 64'(req_addr_o), 64'(q_addr[0]));
                    chk({tag, " len"}, 64'(req_len_o), 64'(q_len[0]));
                    outstanding = int'(q_len[0]) + 1;
                    void'(q_addr.pop_front());
                    void'(q_len.pop_front());
                end
            end
            if (hold > 0)
                fifo_level_i = (cyc + 1 < hold) ? LW'($urandom_range(57, 64)) : LW'($urandom_range(0, 56));
            else
                fifo_level_i = rnd ? LW'($urandom_range(0, 64)) : LW'(0);
            prev_level = int'(fifo_level_i);
            @(negedge clk);
        end
        frame_start_i = 1'b0;
        rsp_valid_i   = 1'b0;
        req_ready_i   = 1'b0;
        fifo_level_i  = LW'(0);
        chk({tag, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        chk({tag, " bursts_left"}, 64'(q_addr.size()), 64'd0);
        chk({tag, " beats_left"}, 64'(outstanding), 64'd0);
        chk({tag, " extra_req"}, 64'(extra), 64'd0);
        chk({tag, " overlap"}, 64'(overlap), 64'd0);
        chk({tag, " done_pulse"}, 64'(frame_done_o), 64'd0);
        chk({tag, " busy_end"}, 64'(busy_o), 64'd0);
        if (hold > 0) begin
            chk({tag, " hold_viol"}, 64'(hold_viol), 64'd0);
            chk({tag, " resume"}, 64'(first_req >= hold && first_req <= hold + 1), 64'd1);
        end else if (!rnd && restart_at == 0) begin
            if (exp_nreq > 0) chk({tag, " req_latency"}, 64'(first_req), 64'd1);
            else              chk({tag, " done_latency"}, 64'(done_cyc), 64'd1);
        end
    endtask

    initial begin
        int  seen;
        bit  acc;
        rst_i = 1'b1; en_i = 1'b0; frame_start_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
        brulen_i = 8'd0; fbstart_i = '0; fbsize_i = '0; fifo_level_i = '0;
`ifdef VGA_FETCH_UNDERRUN_EN
        fifo_empty_i = 1'b0; de_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst req_valid", 64'(req_valid_o), 64'd0);
        chk("rst req_addr", 64'(req_addr_o), 64'd0);
        chk("rst req_len", 64'(req_len_o), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst frame_done", 64'(frame_done_o), 64'd0);
`ifdef VGA_FETCH_UNDERRUN_EN
        chk("rst underrun", 64'(underrun_o), 64'd0);
        chk("rst underrun_cnt", 64'(underrun_cnt_o), 64'd0);
`endif
        rst_i = 1'b0;
        en_i  = 1'b1;
        @(negedge clk);

        run_frame("base", 32'h8000_0000, 32'h400, 8'd15, 1'b0, 0, 0);
        run_frame("tail", 32'h8000_0000, 32'h104, 8'd15, 1'b0, 0, 0);
        run_frame("throttle", 32'h0000_2000, 32'h40, 8'd7, 1'b0, 0, 12);
        run_frame("restart", 32'h0001_0000, 32'h100, 8'd7, 1'b0, 3, 0);
        run_frame("wrap", 32'hFFFF_FFC0, 32'h80, 8'd15, 1'b0, 0, 0);
        run_frame("tiny", 32'h0000_4000, 32'($urandom_range(0, 3)), 8'd3, 1'b0, 0, 0);
        run_frame("unaligned", 32'h0000_5003, 32'h2B, 8'd2, 1'b0, 0, 0);

        // Disable mid-burst: the burst finishes, then nothing more is requested.
        fbstart_i = 32'h0000_1000; fbsize_i = 32'h100; brulen_i = 8'd7;
        @(negedge clk); frame_start_i = 1'b1;
        @(negedge clk); frame_start_i = 1'b0; req_ready_i = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            if (req_valid_o) acc = 1'b1;
            @(negedge clk);
        end
        chk("endrop accepted", 64'(acc), 64'd1);
        req_ready_i = 1'b0; en_i = 1'b0;
        repeat (7) begin rsp_valid_i = 1'b1; @(negedge clk); end
        rsp_valid_i = 1'b0;
        chk("endrop busy_mid", 64'(busy_o), 64'd1);
        rsp_valid_i = 1'b1; @(negedge clk); rsp_valid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            seen += int'(req_valid_o) + int'(frame_done_o);
            @(negedge clk);
        end
        chk("endrop quiet", 64'(seen), 64'd0);
        chk("endrop busy_end", 64'(busy_o), 64'd0);

        // Disabled in ARM: a frame start is ignored.
        en_i = 1'b1; @(negedge clk);
        en_i = 1'b0; @(negedge clk);
        frame_start_i = 1'b1; @(negedge clk); frame_start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            seen += int'(req_valid_o) + int'(busy_o) + int'(frame_done_o);
            @(negedge clk);
        end
        chk("disabled quiet", 64'(seen), 64'd0);
        en_i = 1'b1; @(negedge clk);

        for (int k = 0; k < 4; k++)
            run_frame("random", {$urandom} & 32'hFFFF_FFFC, 32'($urandom_range(4, 512)),
                      8'($urandom_range(0, 31)), 1'b1, 0, 0);

`ifdef VGA_FETCH_UNDERRUN_EN
        @(negedge clk);
        de_i = 1'b1; fifo_empty_i = 1'b1;
        repeat (5) @(negedge clk);
        de_i = 1'b0; fifo_empty_i = 1'b0;
        @(negedge clk);
        chk("underrun flag", 64'(underrun_o), 64'd1);
        chk("underrun cnt", 64'(underrun_cnt_o), 64'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
